// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state encoding, latency counter width and index-width helper
package cpu_mem_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int LAT_W = 4;
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage load/store bus; misalign_o exists only with DMEM_ALIGN_CHECK_EN
interface dmem_responder_if;
  logic MemRead_i;
  logic MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic ack_o;
  logic stall_o;
`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_o;
  modport master(output MemRead_i, MemWrite_i, addr_i, data_i, input data_o, ack_o, stall_o, misalign_o);
  modport slave(input MemRead_i, MemWrite_i, addr_i, data_i, output data_o, ack_o, stall_o, misalign_o);
`else
  modport master(output MemRead_i, MemWrite_i, addr_i, data_i, input data_o, ack_o, stall_o);
  modport slave(input MemRead_i, MemWrite_i, addr_i, data_i, output data_o, ack_o, stall_o);
`endif
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W storage, synchronous write, registered read
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int DATA_W = 32,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic              kill,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // storage is never cleared; a killed access leaves it untouched
  always_ff @(posedge clk)
    if (en && we && !kill) mem[addr] <= wdata;
  // read port doubles as the held load-data register; writes and killed accesses return zero
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (en) rdata <= (we || kill) ? '0 : mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with stall/ack handshake; option DMEM_ALIGN_CHECK_EN adds misalign_o
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH = 256,
  parameter int DATA_W = 32
) (
  input logic clk_i,
  input logic rst_i,
  dmem_responder_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  logic [1:0] state, state_nx;
  logic [LAT_W-1:0] cnt;
  logic [AW-1:0] addr_q, addr_c;
  logic [DATA_W-1:0] wdata_q, wdata_c;
  logic we_q, we_c, mis_q, mis_in, mis_c, req, accept, commit, unused;
  assign req = bus.MemRead_i | bus.MemWrite_i;
  assign accept = state == IDLE && req;
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_in = |bus.addr_i[1:0];
`else
  assign mis_in = 1'b0;
`endif
  assign unused = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};
  // with LATENCY=1 the access commits straight from the live request in IDLE
  assign commit = (accept && LATENCY == 1) || (state == BUSY && cnt == LAT_W'(1));
  assign addr_c = state == IDLE ? bus.addr_i[AW+1:2] : addr_q;
  assign wdata_c = state == IDLE ? bus.data_i : wdata_q;
  assign we_c = state == IDLE ? bus.MemWrite_i : we_q;
  assign mis_c = state == IDLE ? mis_in : mis_q;
  // state register
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  // latency countdown from acceptance
  always_ff @(posedge clk_i)
    if (rst_i) cnt <= '0;
    else if (accept) cnt <= LAT_W'(LATENCY - 1);
    else if (state == BUSY) cnt <= cnt - 1'b1;
  // capture the request so later input changes are ignored
  always_ff @(posedge clk_i)
    if (accept) begin
      addr_q <= bus.addr_i[AW+1:2];
      wdata_q <= bus.data_i;
      we_q <= bus.MemWrite_i;
      mis_q <= mis_in;
    end
  // next-state logic
  always_comb
    state_nx = state == IDLE ? (req ? (LATENCY > 1 ? BUSY : DONE) : IDLE)
             : state == BUSY ? (cnt == LAT_W'(1) ? DONE : BUSY)
             : IDLE;
  // handshake outputs
  always_comb begin
    bus.stall_o = accept || state == BUSY;
    bus.ack_o = state == DONE;
`ifdef DMEM_ALIGN_CHECK_EN
    bus.misalign_o = state == DONE && mis_q;
`endif
  end
  dmem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_array (
    .clk(clk_i),
    .rst(rst_i),
    .en(commit && !rst_i),
    .we(we_c),
    .kill(mis_c),
    .addr(addr_c),
    .wdata(wdata_c),
    .rdata(bus.data_o)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random accesses on LATENCY=4 and LATENCY=1 responders against a word-array model
module tb_dmem_responder;
  logic clk = 0;
  logic rst = 1;
  logic [1:0] rd = 0;
  logic [1:0] wr = 0;
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  int checks = 0;
  int errors = 0;
  bit [31:0] model [int];
  dmem_responder_if b4();
  dmem_responder_if b1();
  dmem_responder #(.LATENCY(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(b4));
  dmem_responder #(.LATENCY(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  assign b4.MemRead_i = rd[0];
  assign b4.MemWrite_i = wr[0];
  assign b4.addr_i = ad[0];
  assign b4.data_i = wd[0];
  assign b1.MemRead_i = rd[1];
  assign b1.MemWrite_i = wr[1];
  assign b1.addr_i = ad[1];
  assign b1.data_i = wd[1];
  wire [1:0] ack = {b1.ack_o, b4.ack_o};
  wire [1:0] stl = {b1.stall_o, b4.stall_o};
  wire [31:0] dout [2];
  assign dout[0] = b4.data_o;
  assign dout[1] = b1.data_o;
`ifdef DMEM_ALIGN_CHECK_EN
  wire [1:0] mis_o = {b1.misalign_o, b4.misalign_o};
`endif
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one full access on unit u; leaves the bench at the ack cycle with strobes dropped
  task automatic access(input int u, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    int key;
    int lat;
    bit mis;
    bit known;
    logic [31:0] exp;
    key = u * 1024 + int'((a >> 2) % 256);
    lat = u == 1 ? 1 : 4;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = a % 4 != 0;
`else
    mis = 0;
`endif
    known = w || mis || model.exists(key);
    exp = (w || mis) ? 32'h0 : (model.exists(key) ? model[key] : 32'h0);
    @(negedge clk);
    rd[u] = r;
    wr[u] = w;
    ad[u] = a;
    wd[u] = d;
    for (int i = 0; i < lat; i++) begin
      #1;
      chk($sformatf("stall u%0d a%h c%0d", u, a, i), 32'(stl[u]), 32'h1);
      chk($sformatf("early_ack u%0d a%h c%0d", u, a, i), 32'(ack[u]), 32'h0);
      @(negedge clk);
    end
    #1;
    chk($sformatf("ack u%0d a%h", u, a), 32'(ack[u]), 32'h1);
    chk($sformatf("stall_in_ack u%0d a%h", u, a), 32'(stl[u]), 32'h0);
    if (known) chk($sformatf("data u%0d a%h", u, a), dout[u], exp);
`ifdef DMEM_ALIGN_CHECK_EN
    chk($sformatf("misalign u%0d a%h", u, a), 32'(mis_o[u]), 32'(mis));
`endif
    rd[u] = 0;
    wr[u] = 0;
    if (w && !mis) model[key] = d;
  endtask

  initial begin
    logic [31:0] hold;
    ad[0] = 0;
    ad[1] = 0;
    wd[0] = 0;
    wd[1] = 0;
    repeat (2) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_ack u%0d", u), 32'(ack[u]), 32'h0);
      chk($sformatf("rst_stall u%0d", u), 32'(stl[u]), 32'h0);
      chk($sformatf("rst_data u%0d", u), dout[u], 32'h0);
    end
    rst = 0;
    access(0, 0, 1, 32'h10, 32'hDEADBEEF);
    access(0, 1, 0, 32'h10, 32'h0);
    @(negedge clk);
    #1;
    chk("hold_data", dout[0], 32'hDEADBEEF);
    chk("hold_ack", 32'(ack[0]), 32'h0);
    chk("idle_stall", 32'(stl[0]), 32'h0);
    access(1, 0, 1, 32'h0, 32'h12345678);
    access(1, 1, 0, 32'h0, 32'h0);
    access(0, 0, 1, 32'h400, 32'hA5A5A5A5);
    access(0, 1, 0, 32'h000, 32'h0);
    access(0, 0, 1, 32'h20, 32'h22222222);
    @(negedge clk);
    wr[0] = 1;
    ad[0] = 32'h20;
    wd[0] = 32'h11111111;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    wr[0] = 0;
    @(negedge clk);
    #1;
    chk("midrst_stall", 32'(stl[0]), 32'h0);
    chk("midrst_ack", 32'(ack[0]), 32'h0);
    chk("midrst_data", dout[0], 32'h0);
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("post_rst_ack", 32'(ack[0]), 32'h0);
      chk("post_rst_stall", 32'(stl[0]), 32'h0);
    end
    access(0, 1, 0, 32'h20, 32'h0);
    access(0, 1, 1, 32'h30, 32'h5);
    access(0, 1, 0, 32'h30, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    access(0, 0, 1, 32'h33, 32'hFF);
    access(0, 1, 0, 32'h30, 32'h0);
`endif
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++) access(u, 0, 1, 32'(i * 4), $urandom);
    for (int n = 0; n < 60; n++) begin
      int u;
      int kind;
      logic [31:0] a;
      u = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      access(u, kind != 1, kind != 0, a, $urandom);
    end
    hold = dout[0];
    @(negedge clk);
    #1;
    chk("final_hold", dout[0], hold);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the far side of the pipeline's MEM-stage load/store interface.
- Accepts MemRead/MemWrite requests from EX/MEM and holds the pipeline with stall_o for a fixed latency.
- Completes each access with a one-cycle ack_o, supplying read data to MEM/WB in that cycle.
- Replaces the single-cycle data memory so the CPU's stall path can be exercised against realistic memory latency.

Parameters:
- LATENCY, 4, cycles from request acceptance to ack; legal range 1..15.
- DEPTH, 256, number of 32-bit words in the backing array; power of two.
- DATA_W, 32, data width in bits; fixed at 32.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- MemRead_i  in  1  load request.
- MemWrite_i  in  1  store request.
- addr_i  in  32  byte address.
- data_i  in  32  store data.
- data_o  out  32  load data; valid while ack_o=1.
- ack_o  out  1  access-complete pulse.
- stall_o  out  1  pipeline freeze (PC, IF/ID, ID/EX, EX/MEM hold).

Behaviour:
- Interface: one clock; reset is synchronous and active-high, sampled on the rising edge of clk_i.
- Reset values: data_o=0, ack_o=0, state=IDLE, counter=0. stall_o follows its combinational rule: 0 unless a request is present in IDLE.
- Array contents are not cleared by reset.
- States:
  - IDLE: if MemRead_i|MemWrite_i, latch addr/data/we (we=MemWrite_i) and load counter=LATENCY-1. Go to BUSY if LATENCY>1, else go to DONE.
  - BUSY: decrement counter. At counter==1, go to DONE and commit the access on that edge. A write updates array[word]; a read registers array[word] into data_o.
  - DONE: ack_o=1, stall_o=0. Next state is IDLE.
- stall_o (combinational) = (IDLE & (MemRead_i|MemWrite_i)) | BUSY.
- Latency: request first visible at cycle t -> ack_o in cycle t+LATENCY. stall_o is high for exactly LATENCY cycles (t..t+LATENCY-1).
- No re-acceptance: stall_o is low in DONE, so the pipeline advances and the request visible in the following IDLE cycle is the next instruction's.
- Back-to-back requests: IDLE->BUSY with no bubble beyond the DONE cycle. Throughput is one access per LATENCY+1 cycles.
- Word index = addr_i[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- MemRead_i and MemWrite_i both high: treated as a write; data_o=0 in the ack cycle.
- Inputs changing or deasserting during BUSY are ignored; the latched request completes.
- data_o holds its last value outside DONE. A write ack drives data_o=0.
- Reset mid-operation: return to IDLE and abandon the pending access. An uncommitted write is never committed; no ack is produced.
- Reset overrides every other input in the same cycle.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: adds output misalign_o (1 bit, reset 0). Requests with addr_i[1:0]!=0 are still accepted and acked after LATENCY cycles. In the ack cycle misalign_o=1, the write is suppressed, and data_o=0. Aligned accesses keep misalign_o=0.
- Undefined: no misalign_o port; addr_i[1:0] is ignored.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - state encoding localparams (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - LAT_W=4;
  - a word-index width function clog2(DEPTH).
- One sub-module, dmem_array: a synchronous-write, registered-read DEPTH x 32 storage with we/addr/wdata/rdata.
- FSM, counter and handshake live in dmem_responder.

Test Plan:
- Store then load, LATENCY=4: MemWrite addr 0x10 data 0xDEADBEEF. Expect stall_o high 4 cycles, ack in the 5th. Then MemRead 0x10: expect ack with data_o=0xDEADBEEF, stall_o low in the ack cycle.
- LATENCY=1: MemRead at 0x0 after array preload 0x12345678. Expect stall_o high 1 cycle, ack next cycle with data_o=0x12345678.
- Wrap-around, DEPTH=256: write 0xA5A5A5A5 to 0x400. Read 0x000 -> data_o=0xA5A5A5A5.
- Reset mid-access: write 0x11111111 to 0x20, assert rst_i in the 2nd BUSY cycle. Expect no ack, stall_o=0 after reset. A subsequent read of 0x20 returns the prior value, not 0x11111111.
- Both strobes high: MemRead=MemWrite=1, addr 0x30, data 0x5. Expect ack with data_o=0; a later read of 0x30 returns 0x5.
- DMEM_ALIGN_CHECK_EN: write to 0x33 with data 0xFF. Expect ack with misalign_o=1. A read of 0x30 returns the prior contents, and misalign_o=0 on that aligned read.
